cdb_broadcaster: RTL and testbench
==================================

// Module: cdb_broadcaster
// PURPOSE
//  Transmit side of the common data bus (CDB). Collects completed results from FU_COUNT functional
//  units, arbitrates round-robin, and drives one broadcast per cycle (cdbtransmit/cdbid/cdbval/cdbrobid).
//  Reservation stations in the issuer and the ROB consume the broadcast. Also drives fus_busy back to the issuer.
// PARAMETERS
//  FU_COUNT  8  number of functional units / result sources
//  DATA_W    8  result value width (cdbval)
//  TAG_W     4  physical-register tag width (cdbid)
//  ROB_W     8  ROB index width (cdbrobid)
// PORTS
//  clk          in   1                 clock, rising edge
//  rst          in   1                 synchronous, active-high reset
//  flush        in   1                 pipeline flush: drop all buffered results
//  fu_valid     in   FU_COUNT          FU i presents a result this cycle
//  fu_ready     out  FU_COUNT          FU i result accepted when fu_valid[i] & fu_ready[i] at clk edge
//  fu_val       in   [FU_COUNT][DATA_W]  result value per FU
//  fu_tag       in   [FU_COUNT][TAG_W]   destination phys-reg tag per FU
//  fu_robid     in   [FU_COUNT][ROB_W]   ROB index per FU
//  cdbtransmit  out  1                 broadcast valid (registered)
//  cdbid        out  TAG_W             broadcast tag (registered)
//  cdbval       out  DATA_W            broadcast value (registered)
//  cdbrobid     out  ROB_W             broadcast ROB index (registered)
//  fus_busy     out  FU_COUNT          FU i holds an unbroadcast result (= hold_valid[i])
// BEHAVIOUR
//  - Per FU one holding register {hold_valid, val, tag, robid}. Accept on valid&ready edge.
//  - fu_ready[i] = ~hold_valid[i] | grant[i]  (combinational; same-cycle refill allowed when granted).
//  - grant: one-hot, combinational over hold_valid, round-robin starting at rr_ptr; zero if none held.
//  - Granted entry copied to CDB output regs at next edge; its hold_valid clears unless refilled same edge.
//  - rr_ptr <= index(grant)+1 mod FU_COUNT on any grant (wraps FU_COUNT-1 -> 0); unchanged if no grant.
//  - cdbtransmit <= |grant; with no grant, cdbtransmit=0 and cdbid/cdbval/cdbrobid hold last values.
//  - Latency: accept at edge k -> cdbtransmit high during cycle after edge k+1 if uncontended; each
//    broadcast lasts exactly one cycle. Throughput: one result per cycle aggregate; one per cycle per FU
//    when that FU is granted every cycle (sole requester).
//  - Worst-case wait for a held entry: FU_COUNT-1 grants (starvation-free).
//  - flush (priority over all but rst): all hold_valid<=0, cdbtransmit<=0, fu_ready forced 0 that cycle,
//    rr_ptr unchanged; results presented during flush are dropped.
//  - rst (priority over everything): hold_valid=0, rr_ptr=0, cdbtransmit=0, cdbid=0, cdbval=0,
//    cdbrobid=0; during rst fu_ready=0, fus_busy=0. Reset mid-broadcast kills pending results silently.
//  - No tag filtering: tag 0 broadcast like any other. Values passed unmodified; no arithmetic.
//  - Outputs settle from registers only, except fu_ready (combinational from hold_valid, grant, flush, rst).
// STRUCTURE
//  - cdb_pkg: DATA_W/TAG_W/ROB_W localparams, typedef struct packed {tag, val, robid} cdb_msg_t,
//    shared with issuer and ROB.
//  - Sub-module rr_arbiter #(N): inputs req[N], ptr[$clog2(N)]; output one-hot grant[N], grant_idx.
//  - Top: hold regs array of cdb_msg_t, rr_ptr reg, output reg stage.
// TESTING
//  1 reset: hold rst 2 cycles with fu_valid=FF -> cdbtransmit=0, fus_busy=00, fu_ready=00; after rst, FU accepts.
//  2 single FU: FU0 {tag=1,val=AA,rob=01} 1 cycle -> next cycle cdbtransmit=1,cdbid=1,cdbval=AA,cdbrobid=01,
//    then 0.
//  3 contention: FU1,FU3,FU6 valid same edge, rr_ptr=0 -> broadcasts in order 1,3,6 on 3 consecutive cycles;
//    fus_busy drains 4A->48->40->00.
//  4 wrap: rr_ptr=7 after FU6 grant, FU0 and FU7 both held -> FU7 first, then FU0; rr_ptr then 1.
//  5 streaming: FU2 sole requester, fu_valid held high 5 cycles with tags 1..5 -> 5 back-to-back broadcasts,
//    fu_ready[2] stays 1.
//  6 flush: FU4,FU5 held, assert flush 1 cycle -> no broadcast of either, fus_busy=00, cdbtransmit=0 next cycle.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions: bus widths and the broadcast message format.
// Also used by the issuer and the ROB.
package cdb_pkg;

    localparam int FU_COUNT = 8;
    localparam int DATA_W   = 8;
    localparam int TAG_W    = 4;
    localparam int ROB_W    = 8;
    localparam int PTR_W    = $clog2(FU_COUNT);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
        logic [ROB_W-1:0]  robid;
    } cdb_msg_t;

    // Round-robin successor of a granted index; wraps the last FU back to FU 0.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        logic [PTR_W-1:0] nxt;
        if (idx == PTR_W'(FU_COUNT - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = idx + PTR_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
// grant is all-zero when there are no requests.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    // Scan requesters in priority order ptr, ptr+1, ... and take the first one found.
    always_comb begin
        int  idx;
        logic found_s;
        grant     = {N{1'b0}};
        grant_idx = {IDX_W{1'b0}};
        found_s   = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found_s && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: per-FU holding registers, round-robin arbitration and a
// registered broadcast stage driving one result per cycle onto the bus.
module cdb_broadcaster
    import cdb_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [FU_COUNT-1:0]              fu_valid,
    output logic [FU_COUNT-1:0]              fu_ready,
    input  logic [FU_COUNT-1:0][DATA_W-1:0]  fu_val,
    input  logic [FU_COUNT-1:0][TAG_W-1:0]   fu_tag,
    input  logic [FU_COUNT-1:0][ROB_W-1:0]   fu_robid,
    output logic                             cdbtransmit,
    output logic [TAG_W-1:0]                 cdbid,
    output logic [DATA_W-1:0]                cdbval,
    output logic [ROB_W-1:0]                 cdbrobid,
    output logic [FU_COUNT-1:0]              fus_busy
);

    logic [FU_COUNT-1:0] hold_valid_r;
    cdb_msg_t            hold_msg_r [FU_COUNT];
    logic [PTR_W-1:0]    rr_ptr_r;
    logic                cdb_tx_r;
    cdb_msg_t            cdb_msg_r;

    logic [FU_COUNT-1:0] grant_s;
    logic [PTR_W-1:0]    grant_idx_s;
    logic                any_grant_s;
    logic [FU_COUNT-1:0] accept_s;
    cdb_msg_t            grant_msg_s;

    rr_arbiter #(
        .N     (FU_COUNT),
        .IDX_W (PTR_W)
    ) u_arb (
        .req       (hold_valid_r),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Handshake: a slot can be refilled in the same cycle its entry is granted.
    always_comb begin
        fu_ready    = {FU_COUNT{1'b0}};
        any_grant_s = |grant_s;
        grant_msg_s = hold_msg_r[grant_idx_s];
        if (rst || flush) begin
            fu_ready = {FU_COUNT{1'b0}};
        end else begin
            fu_ready = ~hold_valid_r | grant_s;
        end
        accept_s = fu_valid & fu_ready;
    end

    // Holding registers, round-robin pointer and the broadcast output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_r <= {FU_COUNT{1'b0}};
            rr_ptr_r     <= {PTR_W{1'b0}};
            cdb_tx_r     <= 1'b0;
            cdb_msg_r    <= '0;
            for (int i = 0; i < FU_COUNT; i++) begin
                hold_msg_r[i] <= '0;
            end
        end else if (flush) begin
            hold_valid_r <= {FU_COUNT{1'b0}};
            cdb_tx_r     <= 1'b0;
        end else begin
            cdb_tx_r <= any_grant_s;
            if (any_grant_s) begin
                cdb_msg_r <= grant_msg_s;
                rr_ptr_r  <= next_ptr(grant_idx_s);
            end
            for (int i = 0; i < FU_COUNT; i++) begin
                if (accept_s[i]) begin
                    hold_valid_r[i]     <= 1'b1;
                    hold_msg_r[i].tag   <= fu_tag[i];
                    hold_msg_r[i].val   <= fu_val[i];
                    hold_msg_r[i].robid <= fu_robid[i];
                end else if (grant_s[i]) begin
                    hold_valid_r[i] <= 1'b0;
                end
            end
        end
    end

    assign cdbtransmit = cdb_tx_r;
    assign cdbid       = cdb_msg_r.tag;
    assign cdbval      = cdb_msg_r.val;
    assign cdbrobid    = cdb_msg_r.robid;
    assign fus_busy    = hold_valid_r;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: directed scenarios plus randomized traffic,
// compared every cycle against a queue-of-results reference model.
module tb_cdb_broadcaster;
    import cdb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                            rst;
    logic                            flush;
    logic [FU_COUNT-1:0]             fu_valid;
    logic [FU_COUNT-1:0]             fu_ready;
    logic [FU_COUNT-1:0][DATA_W-1:0] fu_val;
    logic [FU_COUNT-1:0][TAG_W-1:0]  fu_tag;
    logic [FU_COUNT-1:0][ROB_W-1:0]  fu_robid;
    logic                            cdbtransmit;
    logic [TAG_W-1:0]                cdbid;
    logic [DATA_W-1:0]               cdbval;
    logic [ROB_W-1:0]                cdbrobid;
    logic [FU_COUNT-1:0]             fus_busy;

    cdb_broadcaster dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fu_valid    (fu_valid),
        .fu_ready    (fu_ready),
        .fu_val      (fu_val),
        .fu_tag      (fu_tag),
        .fu_robid    (fu_robid),
        .cdbtransmit (cdbtransmit),
        .cdbid       (cdbid),
        .cdbval      (cdbval),
        .cdbrobid    (cdbrobid),
        .fus_busy    (fus_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one pending result per FU, served in turn order starting at m_ptr.
    bit                 m_known = 1'b0;
    bit                 m_pend  [FU_COUNT];
    logic [TAG_W-1:0]   m_ptag  [FU_COUNT];
    logic [DATA_W-1:0]  m_pval  [FU_COUNT];
    logic [ROB_W-1:0]   m_prob  [FU_COUNT];
    int                 m_ptr = 0;
    bit                 m_tx  = 1'b0;
    logic [TAG_W-1:0]   m_id  = '0;
    logic [DATA_W-1:0]  m_val = '0;
    logic [ROB_W-1:0]   m_rob = '0;

    function automatic int m_pick();
        for (int k = 0; k < FU_COUNT; k++) begin
            int i = (m_ptr + k) % FU_COUNT;
            if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [FU_COUNT-1:0] m_busy();
        logic [FU_COUNT-1:0] b = '0;
        for (int i = 0; i < FU_COUNT; i++) b[i] = m_pend[i];
        return b;
    endfunction

    // Check outputs mid-cycle, then advance the model across the next rising edge.
    task automatic cycle();
        int g;
        logic [FU_COUNT-1:0] exp_ready;
        @(negedge clk);
        g = m_pick();
        for (int i = 0; i < FU_COUNT; i++)
            exp_ready[i] = !rst && !flush && (!m_pend[i] || (i == g));
        if (m_known || rst) check_val("fu_ready", 32'(fu_ready), 32'(exp_ready));
        if (m_known) begin
            check_val("fus_busy", 32'(fus_busy), 32'(m_busy()));
            check_val("cdbtransmit", 32'(cdbtransmit), 32'(m_tx));
            check_val("cdbid", 32'(cdbid), 32'(m_id));
            check_val("cdbval", 32'(cdbval), 32'(m_val));
            check_val("cdbrobid", 32'(cdbrobid), 32'(m_rob));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < FU_COUNT; i++) m_pend[i] = 1'b0;
            m_ptr = 0; m_tx = 1'b0; m_id = '0; m_val = '0; m_rob = '0;
            m_known = 1'b1;
        end else if (flush) begin
            for (int i = 0; i < FU_COUNT; i++) m_pend[i] = 1'b0;
            m_tx = 1'b0;
        end else begin
            if (g >= 0) begin
                m_tx = 1'b1;
                m_id = m_ptag[g]; m_val = m_pval[g]; m_rob = m_prob[g];
                m_pend[g] = 1'b0;
                m_ptr = (g + 1) % FU_COUNT;
            end else begin
                m_tx = 1'b0;
            end
            for (int i = 0; i < FU_COUNT; i++) begin
                if (fu_valid[i] && exp_ready[i]) begin
                    m_pend[i] = 1'b1;
                    m_ptag[i] = fu_tag[i]; m_pval[i] = fu_val[i]; m_prob[i] = fu_robid[i];
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        fu_valid = '0;
        cycle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; fu_valid = '1;
        for (int i = 0; i < FU_COUNT; i++) begin
            fu_tag[i] = TAG_W'(i); fu_val[i] = DATA_W'(8'h10 + i); fu_robid[i] = ROB_W'(8'h20 + i);
        end

        // Reset held two cycles with every FU presenting.
        cycle(); cycle();
        check_val("rst_tx", 32'(cdbtransmit), 32'd0);
        check_val("rst_busy", 32'(fus_busy), 32'h00);
        rst = 1'b0; fu_valid = '0;
        cycle();

        // Single FU0 result.
        fu_valid = 8'h01; fu_tag[0] = 4'h1; fu_val[0] = 8'hAA; fu_robid[0] = 8'h01;
        cycle();
        idle();
        check_val("single_tx", 32'(cdbtransmit), 32'd1);
        check_val("single_id", 32'(cdbid), 32'h1);
        check_val("single_val", 32'(cdbval), 32'hAA);
        check_val("single_rob", 32'(cdbrobid), 32'h01);
        idle();
        check_val("single_tx_off", 32'(cdbtransmit), 32'd0);
        cycle();

        // Contention: FU1, FU3, FU6 together with rr_ptr back at 1 -> served 1,3,6.
        for (int i = 0; i < FU_COUNT; i++) fu_tag[i] = TAG_W'(i);
        fu_valid = 8'h4A;
        cycle();
        check_val("cont_busy0", 32'(fus_busy), 32'h4A);
        idle();
        check_val("cont_id1", 32'(cdbid), 32'h1);
        check_val("cont_busy1", 32'(fus_busy), 32'h48);
        idle();
        check_val("cont_id3", 32'(cdbid), 32'h3);
        check_val("cont_busy2", 32'(fus_busy), 32'h40);
        idle();
        check_val("cont_id6", 32'(cdbid), 32'h6);
        check_val("cont_busy3", 32'(fus_busy), 32'h00);
        idle();

        // Wrap: rr_ptr=7, FU0 and FU7 held -> FU7 then FU0; next contention starts at FU1.
        fu_valid = 8'h81;
        cycle();
        idle();
        check_val("wrap_first", 32'(cdbid), 32'h7);
        idle();
        check_val("wrap_second", 32'(cdbid), 32'h0);
        fu_valid = 8'h03;
        cycle();
        idle();
        check_val("wrap_ptr1", 32'(cdbid), 32'h1);
        idle();
        check_val("wrap_ptr1_next", 32'(cdbid), 32'h0);
        idle();

        // Streaming: FU2 alone, five results back to back.
        for (int t = 1; t <= 5; t++) begin
            fu_valid = 8'h04; fu_tag[2] = TAG_W'(t);
            cycle();
            check_val("stream_ready", 32'(fu_ready[2]), 32'd1);
            if (t >= 2) check_val("stream_id", 32'(cdbid), 32'(t - 1));
        end
        idle();
        check_val("stream_last", 32'(cdbid), 32'h5);
        check_val("stream_last_tx", 32'(cdbtransmit), 32'd1);
        idle();

        // Flush with FU4 and FU5 held: neither is broadcast.
        fu_valid = 8'h30;
        cycle();
        fu_valid = 8'hFF; flush = 1'b1;
        cycle();
        check_val("flush_busy", 32'(fus_busy), 32'h00);
        check_val("flush_tx", 32'(cdbtransmit), 32'd0);
        flush = 1'b0; fu_valid = '0;
        cycle();
        check_val("flush_tx_after", 32'(cdbtransmit), 32'd0);

        // Randomized traffic including occasional flush and reset.
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 29) == 0);
            fu_valid = FU_COUNT'($urandom) & FU_COUNT'($urandom);
            for (int i = 0; i < FU_COUNT; i++) begin
                fu_tag[i]   = TAG_W'($urandom);
                fu_val[i]   = DATA_W'($urandom);
                fu_robid[i] = ROB_W'($urandom);
            end
            cycle();
        end
        rst = 1'b0; flush = 1'b0;
        for (int n = 0; n < 10; n++) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
